// File: rtl/axi_defines.sv
// Shared AXI channel payload types and encodings used by the on-chip AXI targets.
package axi_defines;

  localparam int unsigned AXI_ADDR_W     = 32;
  localparam int unsigned AXI_DATA_W     = 32;
  localparam int unsigned AXI_STRB_W     = 8;
  localparam int unsigned AXI_LEN_W      = 8;
  localparam int unsigned AXI_WORD_BYTES = 4;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;

  localparam logic [2:0] AXI_SIZE_WORD   = 3'd2;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            burst;
    logic [2:0]            size;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_ADDR_W-1:0] addr;
  } aw_t;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            burst;
    logic [2:0]            size;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_ADDR_W-1:0] addr;
  } ar_t;

  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [AXI_STRB_W-1:0] strb;
    logic [AXI_DATA_W-1:0] data;
  } w_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] resp;
  } b_t;

  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [AXI_STRB_W-1:0] strb;
    logic [AXI_DATA_W-1:0] data;
  } r_t;

  typedef enum logic [2:0] {
    IDLE,
    W_DATA,
    W_RESP,
    R_ADDR,
    R_DATA
  } axi_slv_state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED/INCR/WRAP bursts with 4-byte beats; flags illegal
// wrap lengths and the reserved burst encoding.
module axi_burst_addr
  import axi_defines::*;
(
  input  logic [AXI_ADDR_W-1:0] i_addr,
  input  logic [AXI_LEN_W-1:0]  i_len,
  input  logic [1:0]            i_burst,
  output logic [AXI_ADDR_W-1:0] o_next_addr,
  output logic                  o_illegal
);

  logic [AXI_ADDR_W-1:0] w_incr;
  logic [AXI_ADDR_W-1:0] w_mask;
  logic                  w_wrap_ok;

  assign w_incr    = i_addr + AXI_ADDR_W'(AXI_WORD_BYTES);
  // Wrap boundary is (len+1)*4 bytes; mask selects the offset inside it.
  assign w_mask    = (AXI_ADDR_W'(i_len) * AXI_ADDR_W'(AXI_WORD_BYTES))
                   | AXI_ADDR_W'(AXI_WORD_BYTES - 1);
  assign w_wrap_ok = (i_len == AXI_LEN_W'(1)) || (i_len == AXI_LEN_W'(3)) ||
                     (i_len == AXI_LEN_W'(7)) || (i_len == AXI_LEN_W'(15));

  always_comb begin
    o_next_addr = w_incr;
    o_illegal   = 1'b0;
    case (i_burst)
      AXI_BURST_FIXED: o_next_addr = i_addr;
      AXI_BURST_INCR:  ;
      AXI_BURST_WRAP: begin
        if (w_wrap_ok) begin
          o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory target: single-port DEPTH x 32 RAM serving write and read bursts,
// one burst at a time, with alternating priority on simultaneous requests.
module axi_mem_slave
  import axi_defines::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  input  aw_t  aw,
  output logic aw_ready,
  input  w_t   w,
  output logic w_ready,
  output b_t   b,
  input  logic b_ready,
  input  ar_t  ar,
  output logic ar_ready,
  output r_t   r,
  input  logic r_ready
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned WORD_LSB = $clog2(AXI_WORD_BYTES);
  localparam int unsigned TAG_LSB  = IDX_W + WORD_LSB;
  localparam logic [AXI_STRB_W-1:0] R_STRB = AXI_STRB_W'(4'hF);

  axi_slv_state_t        r_state;
  axi_slv_state_t        w_state_nxt;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [AXI_LEN_W-1:0]  r_len;
  logic [1:0]            r_burst;
  logic [AXI_LEN_W-1:0]  r_cnt;
  logic                  r_err;
  logic                  r_over;
  logic                  r_prio_wr;
  b_t                    r_bch;
  r_t                    r_rch;
  logic [AXI_DATA_W-1:0] r_mem [DEPTH];

  logic [AXI_ADDR_W-1:0] w_next_addr;
  logic                  w_illegal;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_cnt_end;
  logic                  w_w_hs;
  logic                  w_we;
  logic                  w_err_nxt;
  logic                  w_unused;

  axi_burst_addr u_burst_addr (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr),
    .o_illegal   (w_illegal)
  );

  assign w_idx      = r_addr[TAG_LSB-1:WORD_LSB];
  assign w_in_range = (r_addr[AXI_ADDR_W-1:TAG_LSB] == BASE_ADDR[AXI_ADDR_W-1:TAG_LSB]);
  assign w_cnt_end  = (r_cnt == r_len);
  assign w_w_hs     = w_ready && w.valid;
  assign w_we       = w_w_hs && !r_over && w_in_range && rst_n;
  // A beat is in error if the burst already is, or last disagrees with the count.
  assign w_err_nxt  = r_err || r_over || w_illegal || !w_in_range || (w.last != w_cnt_end);
  assign w_unused   = ^{w.strb[AXI_STRB_W-1:AXI_WORD_BYTES], ar.size};

  assign b = r_bch;
  assign r = r_rch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    aw_ready    = 1'b0;
    ar_ready    = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        aw_ready = aw.valid && (!ar.valid || r_prio_wr);
        ar_ready = ar.valid && (!aw.valid || !r_prio_wr);
        if (aw_ready) begin
          w_state_nxt = W_DATA;
        end else if (ar_ready) begin
          w_state_nxt = R_ADDR;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (w.valid && w.last) begin
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (b_ready) begin
          w_state_nxt = IDLE;
        end
      end
      R_ADDR: w_state_nxt = R_DATA;
      R_DATA: begin
        if (r_ready) begin
          w_state_nxt = r_rch.last ? IDLE : R_ADDR;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_over    <= 1'b0;
      r_prio_wr <= 1'b1;
      r_bch     <= '0;
      r_rch     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (aw_ready) begin
            r_addr  <= aw.addr;
            r_len   <= aw.len;
            r_burst <= aw.burst;
            r_cnt   <= '0;
            r_over  <= 1'b0;
            r_err   <= (aw.size != AXI_SIZE_WORD);
          end else if (ar_ready) begin
            r_addr  <= ar.addr;
            r_len   <= ar.len;
            r_burst <= ar.burst;
            r_cnt   <= '0;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_addr <= w_next_addr;
            r_err  <= w_err_nxt;
            if (!r_over) begin
              r_cnt <= r_cnt + AXI_LEN_W'(1);
            end
            if (!w.last && w_cnt_end) begin
              r_over <= 1'b1;
            end
            if (w.last) begin
              r_bch.valid <= 1'b1;
              r_bch.resp  <= w_err_nxt ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
          end
        end
        W_RESP: begin
          if (b_ready) begin
            r_bch.valid <= 1'b0;
            r_err       <= 1'b0;
            r_prio_wr   <= 1'b0;
          end
        end
        R_ADDR: begin
          r_rch.valid <= 1'b1;
          r_rch.last  <= w_cnt_end;
          r_rch.strb  <= R_STRB;
          r_rch.data  <= w_in_range ? r_mem[w_idx] : '0;
        end
        R_DATA: begin
          if (r_ready) begin
            r_rch.valid <= 1'b0;
            if (r_rch.last) begin
              r_prio_wr <= 1'b1;
            end else begin
              r_addr <= w_next_addr;
              r_cnt  <= r_cnt + AXI_LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-enabled RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned i = 0; i < AXI_WORD_BYTES; i++) begin
        if (w.strb[i]) begin
          r_mem[w_idx][8*i +: 8] <= w.data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: expected B/R results queued at stimulus time.
module tb_axi_mem_slave;
  import axi_defines::*;

  localparam int TMO = 50;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } rexp_t;

  logic clk;
  logic rst_n;
  aw_t  aw;
  ar_t  ar;
  w_t   w;
  b_t   b;
  r_t   r;
  logic aw_ready;
  logic ar_ready;
  logic w_ready;
  logic b_ready;
  logic r_ready;

  int n_chk;
  int n_fail;
  logic [1:0] b_q[$];
  rexp_t      r_q[$];

  axi_mem_slave #(
    .DEPTH     (1024),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .aw       (aw),
    .aw_ready (aw_ready),
    .w        (w),
    .w_ready  (w_ready),
    .b        (b),
    .b_ready  (b_ready),
    .ar       (ar),
    .ar_ready (ar_ready),
    .r        (r),
    .r_ready  (r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [7:0] len,
                       input logic [1:0] burst, input logic [2:0] size);
    logic got;
    int   n;
    aw  = '{valid: 1'b1, burst: burst, size: size, len: len, addr: a};
    got = 1'b0;
    n   = 0;
    while (!got && n < TMO) begin
      @(negedge clk);
      got = aw_ready;
      n++;
      @(posedge clk);
      #1;
    end
    aw.valid = 1'b0;
    chk("aw_accept", 32'(got), 32'd1);
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
    logic got;
    int   n;
    ar  = '{valid: 1'b1, burst: burst, size: AXI_SIZE_WORD, len: len, addr: a};
    got = 1'b0;
    n   = 0;
    while (!got && n < TMO) begin
      @(negedge clk);
      got = ar_ready;
      n++;
      @(posedge clk);
      #1;
    end
    ar.valid = 1'b0;
    chk("ar_accept", 32'(got), 32'd1);
  endtask

  task automatic do_w(input logic [31:0] d, input logic [7:0] strb, input logic last);
    logic got;
    int   n;
    w   = '{valid: 1'b1, last: last, strb: strb, data: d};
    got = 1'b0;
    n   = 0;
    while (!got && n < TMO) begin
      @(negedge clk);
      got = w_ready;
      n++;
      @(posedge clk);
      #1;
    end
    w.valid = 1'b0;
    w.last  = 1'b0;
    chk("w_accept_cycles", 32'(got ? n : TMO), 32'd1);
  endtask

  task automatic do_b();
    logic [1:0] e;
    int         n;
    chk("b_valid_lat", 32'(b.valid), 32'd1);
    e = 2'b11;
    if (b_q.size() > 0) e = b_q.pop_front();
    n = 0;
    @(negedge clk);
    while (!b.valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("b_resp", 32'(b.resp), 32'(e));
    b_ready = 1'b1;
    @(posedge clk);
    #1;
    b_ready = 1'b0;
    chk("b_valid_clr", 32'(b.valid), 32'd0);
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input int nbeats, input logic [31:0] d0,
                             input logic [7:0] strb, input logic [1:0] exp_resp);
    b_q.push_back(exp_resp);
    do_aw(a, len, burst, size);
    for (int i = 0; i < nbeats; i++) begin
      do_w(d0 + 32'(i), strb, i == nbeats - 1);
    end
    do_b();
  endtask

  task automatic push_r(input logic [31:0] d, input logic last);
    r_q.push_back('{data: d, last: last});
  endtask

  task automatic do_r(input int nbeats, input int hold_idx, input int hold_n);
    for (int k = 0; k < nbeats; k++) begin
      int    waits;
      rexp_t e;
      waits = 0;
      do begin
        @(negedge clk);
        waits++;
      end while (!r.valid && waits < TMO);
      chk("r_lat", 32'(waits), 32'd2);
      e = '{data: 32'hDEAD_DEAD, last: 1'b0};
      if (r_q.size() > 0) e = r_q.pop_front();
      chk("r_data", r.data, e.data);
      chk("r_last", 32'(r.last), 32'(e.last));
      chk("r_strb", 32'(r.strb), 32'h0F);
      if (k == hold_idx) begin
        for (int h = 0; h < hold_n; h++) begin
          @(negedge clk);
          chk("bp_valid", 32'(r.valid), 32'd1);
          chk("bp_data", r.data, e.data);
          chk("bp_last", 32'(r.last), 32'(e.last));
        end
      end
      r_ready = 1'b1;
      @(posedge clk);
      #1;
      r_ready = 1'b0;
    end
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input int hold_idx, input int hold_n);
    do_ar(a, len, burst);
    do_r(int'(len) + 1, hold_idx, hold_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int waits;
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    aw      = '0;
    ar      = '0;
    w       = '0;
    b_ready = 1'b0;
    r_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_b_valid", 32'(b.valid), 32'd0);
    chk("rst_r_valid", 32'(r.valid), 32'd0);
    chk("rst_aw_ready", 32'(aw_ready), 32'd0);
    chk("rst_ar_ready", 32'(ar_ready), 32'd0);
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // INCR write then readback
    write_burst(32'h10, 8'd3, AXI_BURST_INCR, AXI_SIZE_WORD, 4, 32'd1, 8'h0F, AXI_RESP_OKAY);
    push_r(32'd1, 1'b0); push_r(32'd2, 1'b0); push_r(32'd3, 1'b0); push_r(32'd4, 1'b1);
    read_burst(32'h10, 8'd3, AXI_BURST_INCR, -1, 0);

    // WRAP read with backpressure on the second beat
    write_burst(32'h10, 8'd3, AXI_BURST_INCR, AXI_SIZE_WORD, 4, 32'hA, 8'h0F, AXI_RESP_OKAY);
    push_r(32'hC, 1'b0); push_r(32'hD, 1'b0); push_r(32'hA, 1'b0); push_r(32'hB, 1'b1);
    read_burst(32'h18, 8'd3, AXI_BURST_WRAP, 1, 5);

    // Byte strobes; upper strobe bits have no effect
    write_burst(32'h40, 8'd0, AXI_BURST_INCR, AXI_SIZE_WORD, 1, 32'h1122_3344, 8'h0F, AXI_RESP_OKAY);
    write_burst(32'h40, 8'd0, AXI_BURST_INCR, AXI_SIZE_WORD, 1, 32'hAABB_CCDD, 8'h05, AXI_RESP_OKAY);
    write_burst(32'h40, 8'd0, AXI_BURST_INCR, AXI_SIZE_WORD, 1, 32'hFFFF_FFFF, 8'hF0, AXI_RESP_OKAY);
    push_r(32'h11BB_33DD, 1'b1);
    read_burst(32'h40, 8'd0, AXI_BURST_INCR, -1, 0);

    // Write error cases
    write_burst(32'h80, 8'd3, AXI_BURST_INCR, AXI_SIZE_WORD, 2, 32'h5, 8'h0F, AXI_RESP_SLVERR);
    write_burst(32'h90, 8'd0, AXI_BURST_INCR, 3'd0, 1, 32'h6, 8'h0F, AXI_RESP_SLVERR);
    write_burst(32'h94, 8'd2, AXI_BURST_WRAP, AXI_SIZE_WORD, 3, 32'h7, 8'h0F, AXI_RESP_SLVERR);
    write_burst(32'hA0, 8'd0, AXI_BURST_INCR, AXI_SIZE_WORD, 2, 32'h8, 8'h0F, AXI_RESP_SLVERR);
    write_burst(32'hB0, 8'd0, 2'd3, AXI_SIZE_WORD, 1, 32'h9, 8'h0F, AXI_RESP_SLVERR);

    // Out-of-range write must not alias onto word 0
    write_burst(32'h0, 8'd0, AXI_BURST_INCR, AXI_SIZE_WORD, 1, 32'hCAFE_F00D, 8'h0F, AXI_RESP_OKAY);
    write_burst(32'h1000, 8'd0, AXI_BURST_INCR, AXI_SIZE_WORD, 1, 32'hDEAD_BEEF, 8'h0F, AXI_RESP_SLVERR);
    push_r(32'h0, 1'b1);
    read_burst(32'h1000, 8'd0, AXI_BURST_INCR, -1, 0);
    push_r(32'hCAFE_F00D, 1'b1);
    read_burst(32'h0, 8'd0, AXI_BURST_INCR, -1, 0);

    // Arbitration: write after a read, read after a write
    aw = '{valid: 1'b1, burst: AXI_BURST_INCR, size: AXI_SIZE_WORD, len: 8'd0, addr: 32'h100};
    ar = '{valid: 1'b1, burst: AXI_BURST_INCR, size: AXI_SIZE_WORD, len: 8'd0, addr: 32'h100};
    #1;
    chk("arb1_aw_ready", 32'(aw_ready), 32'd1);
    chk("arb1_ar_ready", 32'(ar_ready), 32'd0);
    b_q.push_back(AXI_RESP_OKAY);
    do_aw(32'h100, 8'd0, AXI_BURST_INCR, AXI_SIZE_WORD);
    do_w(32'h55, 8'h0F, 1'b1);
    do_b();
    aw = '{valid: 1'b1, burst: AXI_BURST_INCR, size: AXI_SIZE_WORD, len: 8'd0, addr: 32'h104};
    #1;
    chk("arb2_aw_ready", 32'(aw_ready), 32'd0);
    chk("arb2_ar_ready", 32'(ar_ready), 32'd1);
    push_r(32'h55, 1'b1);
    read_burst(32'h100, 8'd0, AXI_BURST_INCR, -1, 0);
    ar = '{valid: 1'b1, burst: AXI_BURST_INCR, size: AXI_SIZE_WORD, len: 8'd0, addr: 32'h104};
    #1;
    chk("arb3_aw_ready", 32'(aw_ready), 32'd1);
    chk("arb3_ar_ready", 32'(ar_ready), 32'd0);
    b_q.push_back(AXI_RESP_OKAY);
    do_aw(32'h104, 8'd0, AXI_BURST_INCR, AXI_SIZE_WORD);
    do_w(32'h66, 8'h0F, 1'b1);
    do_b();
    push_r(32'h66, 1'b1);
    read_burst(32'h104, 8'd0, AXI_BURST_INCR, -1, 0);

    // Reset during the second beat of a 4-beat read aborts the burst
    push_r(32'hA, 1'b0); push_r(32'hB, 1'b0); push_r(32'hC, 1'b0); push_r(32'hD, 1'b1);
    do_ar(32'h10, 8'd3, AXI_BURST_INCR);
    do_r(1, -1, 0);
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!r.valid && waits < TMO);
    chk("abort_beat2_valid", 32'(r.valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_r_valid", 32'(r.valid), 32'd0);
    chk("abort_b_valid", 32'(b.valid), 32'd0);
    chk("abort_state", 32'(dut.r_state), 32'(IDLE));
    r_q.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_no_beats", 32'(r.valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
